// File: rtl/ofs_fim_emif_axi_mm_responder.sv
// AXI4 memory responder standing in for the hard EMIF on the FIM EMIF AXI-MM
// interface. Word-addressed internal RAM, independent write and read engines,
// one outstanding burst per direction, all outputs registered.
module ofs_fim_emif_axi_mm_responder #(
    parameter int ID_WIDTH       = 9,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 8,
    parameter int DATA_WIDTH     = 512,
    parameter int USER_WIDTH     = 1,
    parameter int MEM_DEPTH_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [LEN_WIDTH-1:0]      awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awlock,
    input  logic [3:0]                awcache,
    input  logic [2:0]                awprot,
    input  logic [3:0]                awqos,
    input  logic [USER_WIDTH-1:0]     awuser,

    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic [USER_WIDTH-1:0]     wuser,

    output logic                      bvalid,
    input  logic                      bready,
    output logic [ID_WIDTH-1:0]       bid,
    output logic [1:0]                bresp,
    output logic [USER_WIDTH-1:0]     buser,

    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [LEN_WIDTH-1:0]      arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    input  logic                      arlock,
    input  logic [3:0]                arcache,
    input  logic [2:0]                arprot,
    input  logic [3:0]                arqos,
    input  logic [USER_WIDTH-1:0]     aruser,

    output logic                      rvalid,
    input  logic                      rready,
    output logic [ID_WIDTH-1:0]       rid,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic [USER_WIDTH-1:0]     ruser
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
    localparam int DEPTH      = 1 << MEM_DEPTH_LOG2;

    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DATA  = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    localparam logic [MEM_DEPTH_LOG2-1:0] IDX_ONE = {{(MEM_DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH:0]        WCNT_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH:0]        WCNT_MAX = {(LEN_WIDTH+1){1'b1}};
    localparam logic [LEN_WIDTH-1:0]      RCNT_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write engine state
    logic [1:0]                w_state_q, w_state_d;
    logic                      awready_q, awready_d;
    logic                      wready_q,  wready_d;
    logic                      bvalid_q,  bvalid_d;
    logic [ID_WIDTH-1:0]       bid_q,     bid_d;
    logic [USER_WIDTH-1:0]     buser_q,   buser_d;
    logic [1:0]                bresp_q,   bresp_d;
    logic [MEM_DEPTH_LOG2-1:0] w_idx_q,   w_idx_d;
    logic [LEN_WIDTH-1:0]      w_len_q,   w_len_d;
    logic [LEN_WIDTH:0]        w_cnt_q,   w_cnt_d;
    logic [1:0]                w_burst_q, w_burst_d;
    logic                      w_err_q,   w_err_d;

    // Read engine state
    logic [1:0]                r_state_q, r_state_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q,  rvalid_d;
    logic [ID_WIDTH-1:0]       rid_q,     rid_d;
    logic [USER_WIDTH-1:0]     ruser_q,   ruser_d;
    logic [DATA_WIDTH-1:0]     rdata_q,   rdata_d;
    logic [1:0]                rresp_q,   rresp_d;
    logic                      rlast_q,   rlast_d;
    logic [MEM_DEPTH_LOG2-1:0] r_idx_q,   r_idx_d;
    logic [LEN_WIDTH-1:0]      r_len_q,   r_len_d;
    logic [LEN_WIDTH-1:0]      r_cnt_q,   r_cnt_d;
    logic [1:0]                r_burst_q, r_burst_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [LEN_WIDTH:0] w_len_ext;
    logic w_beat_in_range;
    logic ram_we;
    logic unused_inputs;

    assign aw_hs = awvalid && awready_q;
    assign w_hs  = wvalid && wready_q;
    assign b_hs  = bvalid_q && bready;
    assign ar_hs = arvalid && arready_q;
    assign r_hs  = rvalid_q && rready;

    assign w_len_ext       = {1'b0, w_len_q};
    assign w_beat_in_range = (w_cnt_q <= w_len_ext);
    // WRAP and reserved bursts are rejected, so bit 1 of the burst type marks them
    assign ram_we          = w_hs && !w_burst_q[1] && w_beat_in_range;

    // Size, lock, cache, prot, qos, wuser and the out-of-range address bits carry no meaning here
    assign unused_inputs = ^{awaddr, awsize, awlock, awcache, awprot, awqos, wuser,
                             araddr, arsize, arlock, arcache, arprot, arqos};

    // Write engine next-state: capture AW, consume W beats, track protocol errors, hold B until accepted
    always_comb begin
        logic err_next;
        w_state_d = w_state_q;
        bid_d     = bid_q;
        buser_d   = buser_q;
        bresp_d   = bresp_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        err_next  = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    w_idx_d   = awaddr[BYTE_SHIFT +: MEM_DEPTH_LOG2];
                    w_len_d   = awlen;
                    w_cnt_d   = '0;
                    w_burst_d = awburst;
                    w_err_d   = awburst[1];
                    bid_d     = awid;
                    buser_d   = awuser;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (w_burst_q == BURST_INCR) begin
                        w_idx_d = w_idx_q + IDX_ONE;
                    end
                    if (w_cnt_q != WCNT_MAX) begin
                        w_cnt_d = w_cnt_q + WCNT_ONE;
                    end
                    if (wlast) begin
                        err_next  = w_err_q || (w_cnt_q != w_len_ext);
                        bresp_d   = err_next ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        err_next  = w_err_q || (w_cnt_q > w_len_ext);
                    end
                    w_err_d = err_next;
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read engine next-state: capture AR, fetch one word, present it until accepted, then fetch the next
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        ruser_d   = ruser_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_burst_d = r_burst_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_idx_d   = araddr[BYTE_SHIFT +: MEM_DEPTH_LOG2];
                    r_len_d   = arlen;
                    r_cnt_d   = '0;
                    r_burst_d = arburst;
                    rid_d     = arid;
                    ruser_d   = aruser;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rdata_d   = r_burst_q[1] ? '0 : mem[r_idx_q];
                rresp_d   = r_burst_q[1] ? RESP_SLVERR : RESP_OKAY;
                rlast_d   = (r_cnt_q == r_len_q);
                r_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    rlast_d = 1'b0;
                    if (rlast_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        if (r_burst_q == BURST_INCR) begin
                            r_idx_d = r_idx_q + IDX_ONE;
                        end
                        r_cnt_d   = r_cnt_q + RCNT_ONE;
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // RAM write port: byte-enabled, not reset so contents survive a reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wstrb[i]) begin
                    mem[w_idx_q][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Write engine registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            buser_q   <= '0;
            bresp_q   <= RESP_OKAY;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            buser_q   <= buser_d;
            bresp_q   <= bresp_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
        end
    end

    // Read engine registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            ruser_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            ruser_q   <= ruser_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_burst_q <= r_burst_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign buser   = buser_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign ruser   = ruser_q;

endmodule

// File: tb/tb_ofs_fim_emif_axi_mm_responder.sv
// Self-checking bench for the EMIF AXI-MM responder: a byte-level memory model
// produces expected B and R responses, which a scoreboard compares on each handshake.
module tb_ofs_fim_emif_axi_mm_responder;

    localparam int DW    = 512;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic awvalid = 0; logic awready; logic [8:0] awid = '0; logic [31:0] awaddr = '0;
    logic [7:0] awlen = '0; logic [2:0] awsize = 3'd6; logic [1:0] awburst = 2'd1;
    logic awlock = 0; logic [3:0] awcache = '0; logic [2:0] awprot = '0; logic [3:0] awqos = '0;
    logic [0:0] awuser = '0;
    logic wvalid = 0; logic wready; logic [DW-1:0] wdata = '0; logic [NB-1:0] wstrb = '0;
    logic wlast = 0; logic [0:0] wuser = '0;
    logic bvalid; logic bready = 0; logic [8:0] bid; logic [1:0] bresp; logic [0:0] buser;
    logic arvalid = 0; logic arready; logic [8:0] arid = '0; logic [31:0] araddr = '0;
    logic [7:0] arlen = '0; logic [2:0] arsize = 3'd6; logic [1:0] arburst = 2'd1;
    logic arlock = 0; logic [3:0] arcache = '0; logic [2:0] arprot = '0; logic [3:0] arqos = '0;
    logic [0:0] aruser = '0;
    logic rvalid; logic rready = 0; logic [8:0] rid; logic [DW-1:0] rdata; logic [1:0] rresp;
    logic rlast; logic [0:0] ruser;

    ofs_fim_emif_axi_mm_responder dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awqos(awqos), .awuser(awuser),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .buser(buser),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arqos(arqos), .aruser(aruser),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .ruser(ruser)
    );

    always #5 clk = ~clk;

    typedef struct { logic [8:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [8:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t b_q[$];
    r_exp_t r_q[$];
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] beat_data [16];
    logic [NB-1:0] beat_strb [16];
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] waddr(input int w);
        return 32'(w) << 6;
    endfunction

    // Scoreboard: compare each accepted write response with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bvalid && bready) begin
            checks++;
            if (b_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL b_unexpected: got bid=%0h bresp=%0d, required no response", bid, bresp);
            end else begin
                b_exp_t e;
                e = b_q.pop_front();
                if (bid !== e.id || bresp !== e.resp || buser !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b_resp: got bid=%0h bresp=%0d buser=%0d, required bid=%0h bresp=%0d buser=0",
                             bid, bresp, buser, e.id, e.resp);
                end
            end
        end
    end

    // Scoreboard: compare each accepted read beat with the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            checks++;
            if (r_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL r_unexpected: got rid=%0h rdata[31:0]=%h, required no beat", rid, rdata[31:0]);
            end else begin
                r_exp_t e;
                e = r_q.pop_front();
                if (rid !== e.id || rdata !== e.data || rresp !== e.resp || rlast !== e.last || ruser !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL r_beat: got rid=%0h rresp=%0d rlast=%0d rdata=%h, required rid=%0h rresp=%0d rlast=%0d rdata=%h",
                             rid, rresp, rlast, rdata, e.id, e.resp, e.last, e.data);
                end
            end
        end
    end

    task automatic aw_send(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [8:0] id);
        int t = 0;
        awvalid = 1; awaddr = addr; awlen = 8'(len); awburst = burst; awid = id;
        while (!awready && t < 50) begin @(posedge clk); #1; t++; end
        checks++;
        if (!awready) begin errors++; $display("[TB] FAIL aw_timeout: awready=%0b, required 1", awready); end
        @(posedge clk); #1;
        awvalid = 0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input int len, input logic [1:0] burst, input logic [8:0] id);
        int t = 0;
        arvalid = 1; araddr = addr; arlen = 8'(len); arburst = burst; arid = id;
        while (!arready && t < 50) begin @(posedge clk); #1; t++; end
        checks++;
        if (!arready) begin errors++; $display("[TB] FAIL ar_timeout: arready=%0b, required 1", arready); end
        @(posedge clk); #1;
        arvalid = 0;
    endtask

    task automatic w_send(input logic [DW-1:0] d, input logic [NB-1:0] s, input logic last);
        int t = 0;
        wvalid = 1; wdata = d; wstrb = s; wlast = last;
        while (!wready && t < 50) begin @(posedge clk); #1; t++; end
        checks++;
        if (!wready) begin errors++; $display("[TB] FAIL w_timeout: wready=%0b, required 1", wready); end
        @(posedge clk); #1;
        wvalid = 0; wlast = 0;
    endtask

    // Wait for B, optionally stall it for bdelay cycles checking it holds, then accept it
    task automatic b_wait(input int bdelay);
        int t = 0;
        logic [8:0] id0;
        while (!bvalid && t < 50) begin @(posedge clk); #1; t++; end
        checks++;
        if (!bvalid) begin errors++; $display("[TB] FAIL b_timeout: bvalid=%0b, required 1", bvalid); end
        id0 = bid;
        for (int i = 0; i < bdelay; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bvalid !== 1'b1 || bid !== id0 || awready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b_hold: got bvalid=%0b bid=%0h awready=%0b, required bvalid=1 bid=%0h awready=0",
                         bvalid, bid, awready, id0);
            end
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
    endtask

    // Accept nbeats R beats, optionally toggling rready, checking the payload holds while stalled
    task automatic r_recv(input int nbeats, input bit toggle);
        int beats = 0;
        int cyc = 0;
        bit stall = 0;
        logic [DW-1:0] pdata = '0;
        logic plast = 0;
        while (beats < nbeats && cyc < 200) begin
            if (stall) begin
                checks++;
                if (rvalid !== 1'b1 || rdata !== pdata || rlast !== plast) begin
                    errors++;
                    $display("[TB] FAIL r_hold: got rvalid=%0b rlast=%0b rdata[31:0]=%h, required rvalid=1 rlast=%0b rdata[31:0]=%h",
                             rvalid, rlast, rdata[31:0], plast, pdata[31:0]);
                end
            end
            rready = toggle ? (cyc % 3 != 1) : 1'b1;
            stall = rvalid && !rready;
            pdata = rdata;
            plast = rlast;
            if (rvalid && rready) beats++;
            @(posedge clk); #1;
            cyc++;
        end
        rready = 0;
        checks++;
        if (beats != nbeats) begin
            errors++;
            $display("[TB] FAIL r_count: got %0d beats, required %0d", beats, nbeats);
        end
    endtask

    // Full write burst using beat_data/beat_strb; expected bresp comes from the burst shape
    task automatic write_burst(input int word, input int len, input logic [1:0] burst,
                               input logic [8:0] id, input int nbeats, input int bdelay);
        logic [9:0] idx = 10'(word);
        logic err = burst[1] || (nbeats != len + 1);
        b_q.push_back('{id: id, resp: err ? 2'd2 : 2'd0});
        aw_send(waddr(word), len, burst, id);
        for (int k = 0; k < nbeats; k++) begin
            w_send(beat_data[k], beat_strb[k], k == nbeats - 1);
            if (!burst[1] && k <= len)
                for (int b = 0; b < NB; b++)
                    if (beat_strb[k][b]) model_mem[idx][b*8 +: 8] = beat_data[k][b*8 +: 8];
            if (burst == 2'd1) idx = idx + 10'd1;
        end
        b_wait(bdelay);
    endtask

    // Full read burst; expected beats come from the memory model
    task automatic read_burst(input int word, input int len, input logic [1:0] burst,
                              input logic [8:0] id, input bit toggle, input bit chk_lat);
        logic [9:0] idx = 10'(word);
        for (int k = 0; k <= len; k++) begin
            r_q.push_back('{id: id, data: burst[1] ? '0 : model_mem[idx],
                            resp: burst[1] ? 2'd2 : 2'd0, last: (k == len)});
            if (burst == 2'd1) idx = idx + 10'd1;
        end
        ar_send(waddr(word), len, burst, id);
        if (chk_lat) begin
            checks++;
            if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL r_latency_early: rvalid=%0b, required 0", rvalid); end
            @(posedge clk); #1;
            checks++;
            if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL r_latency: rvalid=%0b, required 1", rvalid); end
        end
        r_recv(len + 1, toggle);
    endtask

    task automatic fill_beats(input logic [7:0] base);
        for (int k = 0; k < 16; k++) begin
            beat_data[k] = {NB{8'(base + 8'(k))}};
            beat_strb[k] = '1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, buser, ruser} !== '0 || rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: awready=%0b arready=%0b bvalid=%0b rvalid=%0b, required all 0",
                     awready, arready, bvalid, rvalid);
        end
        rst_n = 1;
        checks++;
        if (awready !== 1'b0 || arready !== 1'b0) begin
            errors++; $display("[TB] FAIL ready_before_edge: awready=%0b arready=%0b, required 0 0", awready, arready);
        end
        @(posedge clk); #1;
        checks++;
        if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++; $display("[TB] FAIL ready_after_reset: awready=%0b arready=%0b, required 1 1", awready, arready);
        end
    endtask

    task automatic test_single();
        beat_data[0] = {NB{8'hA5}};
        beat_strb[0] = '1;
        write_burst(1, 0, 2'd1, 9'd5, 1, 0);
        read_burst(1, 0, 2'd1, 9'd7, 1'b0, 1'b1);
    endtask

    task automatic test_burst_strobe();
        fill_beats(8'hF0);
        write_burst(2, 3, 2'd1, 9'd1, 4, 0);
        for (int k = 0; k < 4; k++) begin
            beat_data[k] = DW'(k + 1);
            beat_strb[k] = '1;
        end
        beat_strb[1] = NB'(64'hF);
        write_burst(2, 3, 2'd1, 9'd2, 4, 0);
        read_burst(2, 3, 2'd1, 9'd3, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        fill_beats(8'h70);
        write_burst(70, 0, 2'd1, 9'h1AB, 1, 5);
        fill_beats(8'h40);
        write_burst(40, 7, 2'd1, 9'd4, 8, 0);
        read_burst(40, 7, 2'd1, 9'h155, 1'b1, 1'b0);
    endtask

    task automatic test_errors();
        fill_beats(8'h33);
        write_burst(30, 0, 2'd1, 9'd8, 1, 0);
        fill_beats(8'hDE);
        write_burst(30, 0, 2'd2, 9'd9, 1, 0);
        read_burst(30, 0, 2'd1, 9'd10, 1'b0, 1'b0);
        fill_beats(8'h60);
        write_burst(60, 3, 2'd1, 9'd11, 4, 0);
        fill_beats(8'h99);
        write_burst(60, 3, 2'd1, 9'd12, 2, 0);
        checks++;
        if (awready !== 1'b1) begin errors++; $display("[TB] FAIL w_idle_after_err: awready=%0b, required 1", awready); end
        read_burst(60, 3, 2'd1, 9'd13, 1'b0, 1'b0);
        read_burst(2, 1, 2'd3, 9'd14, 1'b0, 1'b0);
    endtask

    task automatic test_wrap_fixed();
        fill_beats(8'h77);
        beat_data[1] = {NB{8'h88}};
        write_burst(DEPTH - 1, 1, 2'd1, 9'd15, 2, 0);
        read_burst(0, 0, 2'd1, 9'd16, 1'b0, 1'b0);
        read_burst(DEPTH - 1, 1, 2'd1, 9'd17, 1'b0, 1'b0);
        fill_beats(8'h10);
        write_burst(20, 3, 2'd0, 9'd18, 4, 0);
        read_burst(20, 0, 2'd1, 9'd19, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        fill_beats(8'h50);
        write_burst(50, 7, 2'd1, 9'd20, 8, 0);
        fill_beats(8'hE0);
        aw_send(waddr(50), 7, 2'd1, 9'd21);
        for (int k = 0; k < 2; k++) begin
            w_send(beat_data[k], '1, 1'b0);
            model_mem[50 + k] = beat_data[k];
        end
        wvalid = 1; wdata = beat_data[2]; wstrb = '1; wlast = 0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, buser, ruser} !== '0 || rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_values: awready=%0b wready=%0b bvalid=%0b bid=%0h rdata[31:0]=%h, required all 0",
                     awready, wready, bvalid, bid, rdata[31:0]);
        end
        wvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (awready !== 1'b1 || bvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mid_release: awready=%0b bvalid=%0b, required 1 0", awready, bvalid);
        end
        read_burst(50, 7, 2'd1, 9'd22, 1'b0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst_strobe();
        test_backpressure();
        test_errors();
        test_wrap_fixed();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (b_q.size() != 0 || r_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d B and %0d R outstanding, required 0 0", b_q.size(), r_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
